// File: rtl/dose_alarm_scheduler_pkg.sv
// Shared widths, FSM encodings and the schedule-entry record for the dose alarm scheduler.
package dose_alarm_scheduler_pkg;
    localparam int HH_W     = 5;
    localparam int MM_W     = 6;
    localparam int SS_W     = 6;
    localparam int MISSED_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZE  = 2'd2;

    typedef struct packed {
        logic            valid;
        logic [HH_W-1:0] hh;
        logic [MM_W-1:0] mm;
    } sched_entry_t;

    function automatic logic time_in_range(input logic [HH_W-1:0] hh, input logic [MM_W-1:0] mm);
        return (hh <= HH_W'(23)) && (mm <= MM_W'(59));
    endfunction
endpackage

// File: rtl/dose_alarm_scheduler_if.sv
// Control/status bundle between the host side and the dose alarm scheduler.
interface dose_alarm_scheduler_if
    import dose_alarm_scheduler_pkg::*;
#(
    parameter int SLOT_W = 2
);
    logic                time_load;
    logic [HH_W-1:0]     time_hh;
    logic [MM_W-1:0]     time_mm;
    logic                sched_we;
    logic [SLOT_W-1:0]   sched_addr;
    logic [HH_W-1:0]     sched_hh;
    logic [MM_W-1:0]     sched_mm;
    logic                sched_valid;
    logic                ack;
    logic                snooze;
    logic                alarm_enable;
    logic                dispense_req;
    logic [MISSED_W-1:0] missed_count;
    logic [HH_W-1:0]     cur_hh;
    logic [MM_W-1:0]     cur_mm;
    logic [SS_W-1:0]     cur_ss;
    logic [1:0]          fsm_state;

    modport master (
        output time_load, time_hh, time_mm, sched_we, sched_addr, sched_hh, sched_mm,
               sched_valid, ack, snooze,
        input  alarm_enable, dispense_req, missed_count, cur_hh, cur_mm, cur_ss, fsm_state
    );

    modport slave (
        input  time_load, time_hh, time_mm, sched_we, sched_addr, sched_hh, sched_mm,
               sched_valid, ack, snooze,
        output alarm_enable, dispense_req, missed_count, cur_hh, cur_mm, cur_ss, fsm_state
    );
endinterface

// File: rtl/dose_alarm_scheduler_tod_counter.sv
// Seconds prescaler plus hh:mm:ss time-of-day with a validated load.
// new_hh/new_mm expose the value being registered so a match can act on the same tick.
module tod_counter
    import dose_alarm_scheduler_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [HH_W-1:0] load_hh,
    input  logic [MM_W-1:0] load_mm,
    output logic            sec_tick,
    output logic            min_tick,
    output logic [HH_W-1:0] hh,
    output logic [MM_W-1:0] mm,
    output logic [SS_W-1:0] ss,
    output logic [HH_W-1:0] new_hh,
    output logic [MM_W-1:0] new_mm
);
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PRE_W-1:0] pre;
    logic [SS_W-1:0]  new_ss;
    logic             load_ok;
    logic             wrap;

    // An out-of-range load is dropped entirely, so the prescaler keeps running too.
    assign load_ok  = load && time_in_range(load_hh, load_mm);
    assign wrap     = (pre == PRE_W'(CLK_HZ - 1));
    assign sec_tick = wrap && !load_ok;
    assign min_tick = sec_tick && (ss == SS_W'(59));

    always_comb begin
        new_hh = hh;
        new_mm = mm;
        new_ss = ss;
        if (load_ok) begin
            new_hh = load_hh;
            new_mm = load_mm;
            new_ss = '0;
        end else if (sec_tick) begin
            if (ss == SS_W'(59)) begin
                new_ss = '0;
                if (mm == MM_W'(59)) begin
                    new_mm = '0;
                    new_hh = (hh == HH_W'(23)) ? '0 : hh + HH_W'(1);
                end else begin
                    new_mm = mm + MM_W'(1);
                end
            end else begin
                new_ss = ss + SS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            hh  <= '0;
            mm  <= '0;
            ss  <= '0;
        end else begin
            pre <= (load_ok || wrap) ? '0 : pre + PRE_W'(1);
            hh  <= new_hh;
            mm  <= new_mm;
            ss  <= new_ss;
        end
    end
endmodule

// File: rtl/dose_alarm_scheduler.sv
// Dose schedule table, minute match and IDLE/RINGING/SNOOZE alarm FSM around a time-of-day counter.
module dose_alarm_scheduler
    import dose_alarm_scheduler_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int N_SLOTS        = 4,
    parameter int RING_TIMEOUT_S = 120,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    dose_alarm_scheduler_if.slave  bus
);
    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int RS_W   = $clog2(RING_TIMEOUT_S + 1);
    localparam int ZS_W   = $clog2(SNOOZE_S + 1);
    localparam int SC_W   = $clog2(MAX_SNOOZE + 1);

    logic                sec_tick, min_tick;
    logic [HH_W-1:0]     cur_hh, new_hh;
    logic [MM_W-1:0]     cur_mm, new_mm;
    logic [SS_W-1:0]     cur_ss;
    sched_entry_t        tbl [N_SLOTS];
    logic [N_SLOTS-1:0]  hit;
    logic                match;
    logic [SLOT_W-1:0]   waddr;

    logic [1:0]          state, nxt_state;
    logic [RS_W-1:0]     ring_sec;
    logic [ZS_W-1:0]     snz_sec;
    logic [SC_W-1:0]     snooze_cnt;
    logic [MISSED_W-1:0] missed;
    logic                alarm_q, dispense_q;
    logic                ring_clr, ring_inc, snz_clr, snz_inc, cnt_clr, cnt_inc, take, miss;

    tod_counter #(.CLK_HZ(CLK_HZ)) u_tod (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (bus.time_load),
        .load_hh  (bus.time_hh),
        .load_mm  (bus.time_mm),
        .sec_tick (sec_tick),
        .min_tick (min_tick),
        .hh       (cur_hh),
        .mm       (cur_mm),
        .ss       (cur_ss),
        .new_hh   (new_hh),
        .new_mm   (new_mm)
    );

    assign waddr = bus.sched_addr;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SLOTS; i++) tbl[i] <= '0;
        end else if (bus.sched_we) begin
            tbl[waddr] <= '{valid: bus.sched_valid, hh: bus.sched_hh, mm: bus.sched_mm};
        end
    end

    // Compare the registered table (pre-write) against the time that is about to be loaded.
    for (genvar i = 0; i < N_SLOTS; i++) begin : g_hit
        assign hit[i] = tbl[i].valid && (tbl[i].hh == new_hh) && (tbl[i].mm == new_mm);
    end
    assign match = min_tick && (|hit);

    always_comb begin
        nxt_state = state;
        ring_clr  = 1'b0;
        ring_inc  = 1'b0;
        snz_clr   = 1'b0;
        snz_inc   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        take      = 1'b0;
        miss      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (match) begin
                    nxt_state = ST_RINGING;
                    ring_clr  = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ST_RINGING: begin
                if (bus.ack) begin
                    nxt_state = ST_IDLE;
                    take      = 1'b1;
                end else if (bus.snooze && (snooze_cnt < SC_W'(MAX_SNOOZE))) begin
                    nxt_state = ST_SNOOZE;
                    cnt_inc   = 1'b1;
                    snz_clr   = 1'b1;
                end else if (sec_tick) begin
                    if (ring_sec == RS_W'(RING_TIMEOUT_S - 1)) begin
                        nxt_state = ST_IDLE;
                        miss      = 1'b1;
                    end else begin
                        ring_inc  = 1'b1;
                    end
                end
            end
            ST_SNOOZE: begin
                if (bus.ack) begin
                    nxt_state = ST_IDLE;
                    take      = 1'b1;
                end else if (sec_tick) begin
                    if (snz_sec == ZS_W'(SNOOZE_S - 1)) begin
                        nxt_state = ST_RINGING;
                        ring_clr  = 1'b1;
                    end else begin
                        snz_inc   = 1'b1;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ring_sec   <= '0;
            snz_sec    <= '0;
            snooze_cnt <= '0;
            missed     <= '0;
            alarm_q    <= 1'b0;
            dispense_q <= 1'b0;
        end else begin
            state      <= nxt_state;
            alarm_q    <= (nxt_state == ST_RINGING);
            dispense_q <= take;
            if (ring_clr)      ring_sec   <= '0;
            else if (ring_inc) ring_sec   <= ring_sec + RS_W'(1);
            if (snz_clr)       snz_sec    <= '0;
            else if (snz_inc)  snz_sec    <= snz_sec + ZS_W'(1);
            if (cnt_clr)       snooze_cnt <= '0;
            else if (cnt_inc)  snooze_cnt <= snooze_cnt + SC_W'(1);
            if (miss && (missed != '1)) missed <= missed + MISSED_W'(1);
        end
    end

    assign bus.alarm_enable = alarm_q;
    assign bus.dispense_req = dispense_q;
    assign bus.missed_count = missed;
    assign bus.cur_hh       = cur_hh;
    assign bus.cur_mm       = cur_mm;
    assign bus.cur_ss       = cur_ss;
    assign bus.fsm_state    = state;
endmodule

// File: tb/tb_dose_alarm_scheduler.sv
// Directed and randomized checks of dose_alarm_scheduler against a seconds-of-day reference model.
module tb_dose_alarm_scheduler;
    localparam int CLK_HZ     = 4;
    localparam int RING_T     = 5;
    localparam int SNOOZE_S   = 3;
    localparam int MAX_SNOOZE = 2;
    localparam int LONG_RING  = 70;
    localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dose_alarm_scheduler_if #(.SLOT_W(2)) bus  ();
    dose_alarm_scheduler_if #(.SLOT_W(2)) busl ();

    assign busl.time_load   = bus.time_load;
    assign busl.time_hh     = bus.time_hh;
    assign busl.time_mm     = bus.time_mm;
    assign busl.sched_we    = bus.sched_we;
    assign busl.sched_addr  = bus.sched_addr;
    assign busl.sched_hh    = bus.sched_hh;
    assign busl.sched_mm    = bus.sched_mm;
    assign busl.sched_valid = bus.sched_valid;
    assign busl.ack         = bus.ack;
    assign busl.snooze      = bus.snooze;

    dose_alarm_scheduler #(.CLK_HZ(CLK_HZ), .N_SLOTS(4), .RING_TIMEOUT_S(RING_T),
                           .SNOOZE_S(SNOOZE_S), .MAX_SNOOZE(MAX_SNOOZE))
        u_dut (.CLOCK_50(clk), .reset(rst), .bus(bus));

    // Long ring timeout so a ring can span a minute boundary.
    dose_alarm_scheduler #(.CLK_HZ(CLK_HZ), .N_SLOTS(4), .RING_TIMEOUT_S(LONG_RING),
                           .SNOOZE_S(SNOOZE_S), .MAX_SNOOZE(MAX_SNOOZE))
        u_dut_long (.CLOCK_50(clk), .reset(rst), .bus(busl));

    int passed = 0;
    int total  = 0;
    bit chk_on = 1'b1;

    // Reference model: time as seconds of day, schedule as minutes of day.
    int m_tod, m_pre, m_mode, m_elapsed, m_snoozes, m_missed;
    bit m_disp;
    int m_slot_min [4];
    bit m_slot_v   [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] tod_of(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        return 32'(h) * 3600 + 32'(m) * 60 + 32'(s);
    endfunction

    task automatic model_reset();
        m_tod = 0; m_pre = 0; m_mode = M_IDLE; m_elapsed = 0; m_snoozes = 0; m_missed = 0; m_disp = 0;
        for (int i = 0; i < 4; i++) begin m_slot_min[i] = 0; m_slot_v[i] = 0; end
    endtask

    task automatic model_update();
        bit load_ok, tick, match;
        int new_tod;
        load_ok = bus.time_load && (bus.time_hh <= 23) && (bus.time_mm <= 59);
        tick    = !load_ok && (m_pre == CLK_HZ - 1);
        new_tod = m_tod;
        if (load_ok)   new_tod = int'(bus.time_hh) * 3600 + int'(bus.time_mm) * 60;
        else if (tick) new_tod = (m_tod + 1) % 86400;
        m_pre = (load_ok || tick) ? 0 : m_pre + 1;
        match = 0;
        if (tick && (new_tod % 60 == 0))
            for (int i = 0; i < 4; i++) if (m_slot_v[i] && m_slot_min[i] * 60 == new_tod) match = 1;
        m_disp = 0;
        if (m_mode == M_IDLE) begin
            if (match) begin m_mode = M_RING; m_elapsed = 0; m_snoozes = 0; end
        end else if (bus.ack) begin
            m_mode = M_IDLE; m_disp = 1;
        end else if (m_mode == M_RING && bus.snooze && m_snoozes < MAX_SNOOZE) begin
            m_mode = M_SNZ; m_snoozes++; m_elapsed = 0;
        end else if (tick) begin
            m_elapsed++;
            if (m_mode == M_RING && m_elapsed == RING_T) begin
                m_mode = M_IDLE;
                if (m_missed < 255) m_missed++;
            end else if (m_mode == M_SNZ && m_elapsed == SNOOZE_S) begin
                m_mode = M_RING; m_elapsed = 0;
            end
        end
        if (bus.sched_we) begin
            m_slot_min[bus.sched_addr] = int'(bus.sched_hh) * 60 + int'(bus.sched_mm);
            m_slot_v[bus.sched_addr]   = bus.sched_valid;
        end
        m_tod = new_tod;
    endtask

    task automatic check_model();
        chk("alarm_enable", 32'(bus.alarm_enable), 32'(m_mode == M_RING));
        chk("dispense_req", 32'(bus.dispense_req), 32'(m_disp));
        chk("missed_count", 32'(bus.missed_count), m_missed);
        chk("fsm_state", 32'(bus.fsm_state), m_mode);
        chk("time_of_day", tod_of(bus.cur_hh, bus.cur_mm, bus.cur_ss), m_tod);
    endtask

    task automatic clear_inputs();
        bus.time_load = 0; bus.time_hh = '0; bus.time_mm = '0;
        bus.sched_we = 0; bus.sched_addr = '0; bus.sched_hh = '0; bus.sched_mm = '0; bus.sched_valid = 0;
        bus.ack = 0; bus.snooze = 0;
    endtask

    task automatic cyc();
        model_update();
        @(posedge clk);
        #1;
        if (chk_on) check_model();
        bus.time_load = 0; bus.sched_we = 0; bus.ack = 0; bus.snooze = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic load_time(input logic [4:0] h, input logic [5:0] m);
        bus.time_load = 1; bus.time_hh = h; bus.time_mm = m;
        cyc();
    endtask

    task automatic write_slot(input logic [1:0] a, input logic [4:0] h, input logic [5:0] m, input logic v);
        bus.sched_we = 1; bus.sched_addr = a; bus.sched_hh = h; bus.sched_mm = m; bus.sched_valid = v;
        cyc();
    endtask

    task automatic wait_state(input string tag, input logic [1:0] target, input int bound);
        int n = 0;
        while (bus.fsm_state !== target && n < bound) begin cyc(); n++; end
        chk(tag, 32'(bus.fsm_state), 32'(target));
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_alarm", 32'(bus.alarm_enable), 0);
        chk("rst_dispense", 32'(bus.dispense_req), 0);
        chk("rst_state", 32'(bus.fsm_state), 0);
        chk("rst_missed", 32'(bus.missed_count), 0);
        chk("rst_time", tod_of(bus.cur_hh, bus.cur_mm, bus.cur_ss), 0);
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", passed, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_model();

        // A second slot matching while still ringing must not restart or queue a ring.
        write_slot(0, 8, 0, 1);
        write_slot(1, 8, 1, 1);
        load_time(7, 59);
        run(240);
        chk("long_ring_start", 32'(busl.alarm_enable), 1);
        chk("long_time_0800", tod_of(busl.cur_hh, busl.cur_mm, busl.cur_ss), 8 * 3600);
        run(248);
        chk("long_ring_past_0801", 32'(busl.fsm_state), 1);
        run(31);
        chk("long_ring_before_timeout", 32'(busl.fsm_state), 1);
        run(1);
        chk("long_timeout_idle", 32'(busl.fsm_state), 0);
        chk("long_missed", 32'(busl.missed_count), 1);
        run(12);
        chk("long_no_queued_ring", 32'(busl.fsm_state), 0);
        write_slot(1, 0, 0, 0);

        // Ring at 08:00 then acknowledge.
        load_time(7, 59);
        run(240);
        chk("ring_0800", 32'(bus.alarm_enable), 1);
        chk("time_0800", tod_of(bus.cur_hh, bus.cur_mm, bus.cur_ss), 8 * 3600);
        bus.ack = 1;
        cyc();
        chk("ack_alarm_off", 32'(bus.alarm_enable), 0);
        chk("ack_dispense", 32'(bus.dispense_req), 1);
        cyc();
        chk("dispense_one_cycle", 32'(bus.dispense_req), 0);

        // Timeout counts a missed dose.
        load_time(7, 59);
        run(240);
        run(19);
        chk("ring_before_timeout", 32'(bus.alarm_enable), 1);
        run(1);
        chk("timeout_alarm_off", 32'(bus.alarm_enable), 0);
        chk("timeout_state", 32'(bus.fsm_state), 0);
        chk("missed_3", 32'(bus.missed_count), 3);

        // Drive missed_count to saturation.
        chk_on = 0;
        while (m_missed < 255) begin
            load_time(7, 59);
            run(262);
        end
        chk_on = 1;
        cyc();
        chk("missed_255", 32'(bus.missed_count), 255);
        load_time(7, 59);
        run(240);
        chk("ring_at_sat", 32'(bus.alarm_enable), 1);
        run(20);
        chk("missed_stays_255", 32'(bus.missed_count), 255);

        // Two snoozes re-ring, the third is ignored; ack beats snooze.
        load_time(7, 59);
        run(240);
        bus.snooze = 1;
        cyc();
        chk("snooze1_state", 32'(bus.fsm_state), 2);
        chk("snooze1_alarm", 32'(bus.alarm_enable), 0);
        wait_state("resnooze1_ring", 1, 20);
        bus.snooze = 1;
        cyc();
        chk("snooze2_state", 32'(bus.fsm_state), 2);
        wait_state("resnooze2_ring", 1, 20);
        bus.snooze = 1;
        cyc();
        chk("snooze3_ignored", 32'(bus.fsm_state), 1);
        chk("snooze3_alarm", 32'(bus.alarm_enable), 1);
        bus.ack = 1; bus.snooze = 1;
        cyc();
        chk("ack_snooze_idle", 32'(bus.fsm_state), 0);
        chk("ack_snooze_dispense", 32'(bus.dispense_req), 1);

        load_time(7, 59);
        run(240);
        bus.ack = 1; bus.snooze = 1;
        cyc();
        chk("ack_over_snooze", 32'(bus.fsm_state), 0);
        chk("ack_over_snooze_disp", 32'(bus.dispense_req), 1);

        load_time(7, 59);
        run(240);
        bus.snooze = 1;
        cyc();
        bus.ack = 1;
        cyc();
        chk("early_take_idle", 32'(bus.fsm_state), 0);
        chk("early_take_disp", 32'(bus.dispense_req), 1);

        // Duplicate entries; invalidation on the tick cycle itself.
        write_slot(2, 8, 0, 1);
        load_time(7, 59);
        run(240);
        chk("dup_ring", 32'(bus.alarm_enable), 1);
        run(20);
        chk("dup_single_timeout", 32'(bus.fsm_state), 0);
        write_slot(2, 0, 0, 0);
        load_time(7, 59);
        run(239);
        bus.sched_we = 1; bus.sched_addr = 0; bus.sched_hh = 8; bus.sched_mm = 0; bus.sched_valid = 0;
        cyc();
        chk("we_on_tick_rings", 32'(bus.alarm_enable), 1);
        bus.ack = 1;
        cyc();
        load_time(7, 59);
        run(240);
        chk("slot_invalidated", 32'(bus.alarm_enable), 0);

        // Midnight wrap and rejected loads.
        write_slot(3, 0, 0, 1);
        load_time(23, 59);
        run(240);
        chk("wrap_time", tod_of(bus.cur_hh, bus.cur_mm, bus.cur_ss), 0);
        chk("wrap_ring", 32'(bus.alarm_enable), 1);
        load_time(24, 30);
        chk("bad_hh_ignored", tod_of(bus.cur_hh, bus.cur_mm, bus.cur_ss), 0);
        load_time(1, 60);
        chk("bad_mm_ignored", tod_of(bus.cur_hh, bus.cur_mm, bus.cur_ss), 0);
        chk("ring_before_reset", 32'(bus.alarm_enable), 1);
        do_reset();

        // Randomized traffic around a handful of near-future dose times.
        for (int i = 0; i < 4; i++)
            write_slot(2'(i), 8, 6'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        load_time(7, 59);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) bus.ack = 1;
            if ($urandom_range(0, 24) == 0) bus.snooze = 1;
            if ($urandom_range(0, 199) == 0) begin
                bus.sched_we = 1; bus.sched_addr = 2'($urandom_range(0, 3));
                bus.sched_hh = 8; bus.sched_mm = 6'($urandom_range(0, 5));
                bus.sched_valid = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 999) == 0) begin
                bus.time_load = 1;
                bus.time_hh = ($urandom_range(0, 3) == 0) ? 5'd24 : 5'd8;
                bus.time_mm = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(60, 63));
            end
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
